// File: rtl/sub_bytes_sequencer.sv
// AES SubBytes over a 128-bit state, time-multiplexing SBOX_COUNT S-box lookups
// across the 16 state bytes behind valid/ready handshakes on both sides.
`default_nettype none

module s_box (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  // Entry 0 sits in the most significant byte of the table.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_idx;

  // Top bit of entry v is 2047-8*v, i.e. {~v, 3'b111}.
  assign w_idx = {~i_in, 3'b111};
  assign o_out = SBOX_TBL[w_idx -: 8];
endmodule

module sub_bytes_sequencer #(
  parameter int SBOX_COUNT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] dataIn,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] dataOut,
  output logic         busy
);
  localparam int PASSES = 16 / SBOX_COUNT;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

  if (!(SBOX_COUNT == 1 || SBOX_COUNT == 2 || SBOX_COUNT == 4 ||
        SBOX_COUNT == 8 || SBOX_COUNT == 16)) begin : g_bad_count
    $fatal(1, "sub_bytes_sequencer: SBOX_COUNT must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_fsm;
  logic [CNT_W-1:0]   r_passCnt;
  logic [127:0]       r_data;
  logic               r_inReady;
  logic               r_outValid;
  logic               r_busy;

  logic [7:0]         w_sbIn  [SBOX_COUNT];
  logic [7:0]         w_sbOut [SBOX_COUNT];
  logic [127:0]       w_dataNext;

  // Lane k of the S-box bank serves byte passCnt*SBOX_COUNT+k.
  always_comb begin
    for (int k = 0; k < SBOX_COUNT; k++) begin
      w_sbIn[k] = 8'h00;
      for (int p = 0; p < PASSES; p++) begin
        if (r_passCnt == CNT_W'(p)) begin
          w_sbIn[k] = r_data[127 - 8*(p*SBOX_COUNT + k) -: 8];
        end
      end
    end
  end

  for (genvar k = 0; k < SBOX_COUNT; k++) begin : g_sbox
    s_box u_sbox (
      .i_in  (w_sbIn[k]),
      .o_out (w_sbOut[k])
    );
  end

  always_comb begin
    w_dataNext = r_data;
    for (int j = 0; j < 16; j++) begin
      if (r_passCnt == CNT_W'(j / SBOX_COUNT)) begin
        w_dataNext[127 - 8*j -: 8] = w_sbOut[j % SBOX_COUNT];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm      <= S_IDLE;
      r_passCnt  <= '0;
      r_data     <= '0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (inValid && r_inReady) begin
            r_data    <= dataIn;
            r_passCnt <= '0;
            r_fsm     <= S_BUSY;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_BUSY: begin
          r_data <= w_dataNext;
          if (r_passCnt == LAST_PASS) begin
            r_passCnt  <= '0;
            r_fsm      <= S_DONE;
            r_busy     <= 1'b0;
            r_outValid <= 1'b1;
          end else begin
            r_passCnt <= r_passCnt + 1'b1;
          end
        end
        S_DONE: begin
          if (r_outValid && outReady) begin
            r_fsm      <= S_IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_fsm      <= S_IDLE;
          r_passCnt  <= '0;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign inReady  = r_inReady;
  assign outValid = r_outValid;
  assign busy     = r_busy;
  assign dataOut  = r_data;
endmodule

`default_nettype wire

// File: tb/tb_sub_bytes_sequencer.sv
// Bench for sub_bytes_sequencer: one instance per legal SBOX_COUNT, checked against
// an S-box built from GF(2^8) inversion plus the AES affine map.
`timescale 1ns/1ps

module tb_sub_bytes_sequencer;
  logic         clk;
  logic         reset;
  logic [4:0]   inValid_v;
  logic [4:0]   outReady_v;
  logic [127:0] dataIn;
  wire  [4:0]   inReady_v;
  wire  [4:0]   outValid_v;
  wire  [4:0]   busy_v;
  wire  [127:0] dataOut_v [5];

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] sbox_ref [256];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_sequencer #(.SBOX_COUNT(1 << g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .inValid  (inValid_v[g]),
      .inReady  (inReady_v[g]),
      .dataIn   (dataIn),
      .outValid (outValid_v[g]),
      .outReady (outReady_v[g]),
      .dataOut  (dataOut_v[g]),
      .busy     (busy_v[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic void build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_ref[s[127 - 8*i -: 8]];
    return r;
  endfunction

  // Runs one transaction on instance d starting at a falling edge; returns dataOut.
  task automatic do_op(input int d, input logic [127:0] din, input bit tie_rdy,
                       input int hold, output logic [127:0] res);
    logic [127:0] exp;
    int lat;
    exp = ref_sub(din);
    dataIn        = din;
    inValid_v[d]  = 1'b1;
    outReady_v[d] = tie_rdy;
    @(negedge clk);
    check("busy_after_accept", 128'(busy_v[d]), 128'd1);
    check("inready_in_busy", 128'(inReady_v[d]), 128'd0);
    lat = 0;
    while (!outValid_v[d] && lat < 40) begin
      inValid_v[d] = 1'($urandom);
      dataIn = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      lat++;
    end
    inValid_v[d] = 1'b0;
    check("latency", 128'(lat), 128'(16 >> d));
    check("outvalid", 128'(outValid_v[d]), 128'd1);
    check("dataout", dataOut_v[d], exp);
    check("busy_in_done", 128'(busy_v[d]), 128'd0);
    res = dataOut_v[d];
    if (!tie_rdy) begin
      for (int c = 0; c < hold; c++) begin
        inValid_v[d] = 1'($urandom);
        dataIn = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        check("hold_dataout", dataOut_v[d], exp);
        check("hold_outvalid", 128'(outValid_v[d]), 128'd1);
        check("hold_inready", 128'(inReady_v[d]), 128'd0);
      end
      inValid_v[d]  = 1'b0;
      outReady_v[d] = 1'b1;
    end
    @(negedge clk);
    outReady_v[d] = 1'b0;
    check("outvalid_drop", 128'(outValid_v[d]), 128'd0);
    check("inready_back", 128'(inReady_v[d]), 128'd1);
  endtask

  initial begin
    logic [127:0] res;
    logic [127:0] st;
    reset      = 1'b0;
    inValid_v  = '0;
    outReady_v = '0;
    dataIn     = '0;
    build_sbox();

    // Asynchronous reset seen before the first clock edge.
    #2 reset = 1'b1;
    #1;
    check("rst_outvalid", 128'(outValid_v), 128'd0);
    check("rst_busy", 128'(busy_v), 128'd0);
    check("rst_inready", 128'(inReady_v), 128'h1f);
    for (int d = 0; d < 5; d++) check("rst_dataout", dataOut_v[d], 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_op(2, 128'h0, 1'b1, 0, res);
    check("zero_state", res, {16{8'h63}});

    for (int d = 0; d < 5; d++) begin
      do_op(d, 128'h000102030405060708090a0b0c0d0e0f, 1'b1, 0, res);
      check("byte_order", res, 128'h637c777bf26b6fc53001672bfed7ab76);
    end

    do_op(2, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 10, res);

    // Abandon an operation at pass 7 on the single-S-box instance.
    dataIn       = {16{8'haa}};
    inValid_v[0] = 1'b1;
    @(negedge clk);
    inValid_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("midop_outvalid", 128'(outValid_v[0]), 128'd0);
    check("midop_busy", 128'(busy_v[0]), 128'd0);
    check("midop_inready", 128'(inReady_v[0]), 128'd1);
    check("midop_dataout", dataOut_v[0], 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(0, {16{8'h53}}, 1'b1, 0, res);
    check("after_reset", res, {16{8'hed}});

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) st[127 - 8*j -: 8] = 8'(16*i + j);
      do_op(2, st, 1'b1, 0, res);
    end

    for (int n = 0; n < 40; n++) begin
      do_op(int'($urandom_range(0, 4)), {$urandom, $urandom, $urandom, $urandom},
            1'($urandom), int'($urandom_range(0, 5)), res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
